div_result_collect: RTL and testbench

DIV_RESULT_COLLECT -- requirements
Module: div_result_collect

---
 rtl/div_result_collect.sv | 141 ++++++++++++++
 tb/tb_div_result_collect.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_result_collect.sv
// Credit-gated, in-order collector of pipelined divider results into a show-ahead FIFO.
// Define DIV_RESULT_COLLECT_DROP_CNT_EN to add the saturating drop_count output.
module div_result_collect #(
   parameter int WIDTH   = 10,
   parameter int LATENCY = 3,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [TAG_W-1:0] issue_tag,
   output logic             issue_ready,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   input  logic             div_error_divide_by_zero,
   input  logic             div_overflow,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [TAG_W-1:0] res_tag,
   output logic [WIDTH-1:0] res_quotient,
   output logic [WIDTH-1:0] res_remainder,
   output logic [1:0]       res_status
`ifdef DIV_RESULT_COLLECT_DROP_CNT_EN
   ,
   output logic [7:0]       drop_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = TAG_W + 2 * WIDTH + 2;

   logic [LATENCY-1:0] tok_vld_q, tok_vld_d;
   logic [TAG_W-1:0]   tok_tag_q [LATENCY];
   logic [TAG_W-1:0]   tok_tag_d [LATENCY];
   logic [EW-1:0]      mem_q [DEPTH];
   logic [EW-1:0]      mem_d [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d, credits_q, credits_d;
   logic               accept_s, push_s, pop_s, full_s;

   assign issue_ready = (credits_q != CW'(0));
   assign res_valid   = (count_q != CW'(0));
   assign full_s      = (count_q == CW'(DEPTH));
   assign accept_s    = issue_valid & issue_ready;
   assign push_s      = tok_vld_q[LATENCY-1];
   assign pop_s       = res_valid & res_ready;
   assign {res_tag, res_quotient, res_remainder, res_status} = mem_q[rd_ptr_q];

   // Token pipeline mirrors the divider: stage 0 is loaded by an accepted issue.
   always_comb begin
      tok_vld_d    = tok_vld_q;
      tok_tag_d    = tok_tag_q;
      tok_vld_d[0] = accept_s;
      tok_tag_d[0] = issue_tag;
      for (int i = 1; i < LATENCY; i++) begin
         tok_vld_d[i] = tok_vld_q[i-1];
         tok_tag_d[i] = tok_tag_q[i-1];
      end
   end

   // FIFO and credit next-state; credits already reserve room for every in-flight token.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q + PW'(push_s);
      rd_ptr_d  = rd_ptr_q + PW'(pop_s);
      count_d   = count_q + CW'(push_s) - CW'(pop_s);
      credits_d = credits_q - CW'(accept_s) + CW'(pop_s);
      if (push_s) begin
         mem_d[wr_ptr_q] = {tok_tag_q[LATENCY-1], div_quotient, div_remainder,
                            div_overflow, div_error_divide_by_zero};
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
   end

   // State registers; storage is cleared so the head reads as zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tok_vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) tok_tag_q[i] <= '0;
         for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         credits_q <= CW'(DEPTH);
      end else begin
         tok_vld_q <= tok_vld_d;
         tok_tag_q <= tok_tag_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         credits_q <= credits_d;
      end
   end

`ifdef DIV_RESULT_COLLECT_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   assign drop_count = drop_cnt_q;

   // Saturating count of issue attempts refused for lack of credit.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (issue_valid && !issue_ready && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end
`endif

   div_result_collect_chk u_chk (
      .clk    (clk),
      .rst    (rst),
      .push_i (push_s),
      .full_i (full_s)
   );

endmodule

// Property checker: a capture into a full FIFO must be impossible.
module div_result_collect_chk (
   input logic clk,
   input logic rst,
   input logic push_i,
   input logic full_i
);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i));
endmodule

// File: tb/tb_div_result_collect.sv
// Directed bench for div_result_collect (LATENCY=3, DEPTH=4) with a tag-derived divider model.
module tb_div_result_collect;
   localparam int WIDTH = 10;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid;
   logic [TAG_W-1:0] issue_tag;
   logic             issue_ready;
   logic [WIDTH-1:0] div_quotient, div_remainder;
   logic             div_error_divide_by_zero, div_overflow;
   logic             res_valid, res_ready;
   logic [TAG_W-1:0] res_tag;
   logic [WIDTH-1:0] res_quotient, res_remainder;
   logic [1:0]       res_status;
`ifdef DIV_RESULT_COLLECT_DROP_CNT_EN
   logic [7:0]       drop_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   div_result_collect #(.WIDTH(WIDTH), .LATENCY(3), .DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .issue_valid              (issue_valid),
      .issue_tag                (issue_tag),
      .issue_ready              (issue_ready),
      .div_quotient             (div_quotient),
      .div_remainder            (div_remainder),
      .div_error_divide_by_zero (div_error_divide_by_zero),
      .div_overflow             (div_overflow),
      .res_valid                (res_valid),
      .res_ready                (res_ready),
      .res_tag                  (res_tag),
      .res_quotient             (res_quotient),
      .res_remainder            (res_remainder),
      .res_status               (res_status)
`ifdef DIV_RESULT_COLLECT_DROP_CNT_EN
      ,
      .drop_count               (drop_count)
`endif
   );

   // Divider model: outputs 3 cycles after a tag is presented, q=tag+2, r=tag^7,
   // tag 8 -> divide-by-zero, tag 9 -> both flags. Runs regardless of acceptance.
   logic [TAG_W-1:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
   always @(posedge clk) begin
      d1 <= issue_tag;
      d2 <= d1;
      d3 <= d2;
   end
   assign div_quotient             = {6'd0, d3} + 10'd2;
   assign div_remainder            = {6'd0, d3 ^ 4'd7};
   assign div_error_divide_by_zero = (d3 == 4'd8) || (d3 == 4'd9);
   assign div_overflow             = (d3 == 4'd9);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic check_res(input string name, input logic [3:0] tag, input logic [9:0] q,
                            input logic [9:0] r, input logic [1:0] st);
      check({name, ".valid"},  {31'd0, res_valid}, 32'd1);
      check({name, ".tag"},    {28'd0, res_tag}, {28'd0, tag});
      check({name, ".q"},      {22'd0, res_quotient}, {22'd0, q});
      check({name, ".r"},      {22'd0, res_remainder}, {22'd0, r});
      check({name, ".status"}, {30'd0, res_status}, {30'd0, st});
   endtask

   initial begin
      // Reset with an issue attempt that must be ignored.
      rst = 1'b1; issue_valid = 1'b1; issue_tag = 4'd3; res_ready = 1'b0;
      tick(); tick();
      check("rst.res_valid",   {31'd0, res_valid}, 32'd0);
      check("rst.issue_ready", {31'd0, issue_ready}, 32'd1);
      check("rst.res_tag",     {28'd0, res_tag}, 32'd0);
      check("rst.res_q",       {22'd0, res_quotient}, 32'd0);
      check("rst.res_r",       {22'd0, res_remainder}, 32'd0);
      check("rst.res_status",  {30'd0, res_status}, 32'd0);

      // Single issue tag 5: q=7 r=2 at cycle 3, result visible at cycle 4.
      rst = 1'b0; issue_valid = 1'b1; issue_tag = 4'd5;
      tick();
      issue_valid = 1'b0; issue_tag = 4'hC;
      tick(); tick();
      check("single.early", {31'd0, res_valid}, 32'd0);
      tick();
      check_res("single", 4'd5, 10'h007, 10'h002, 2'b00);
      res_ready = 1'b1;
      tick();
      check("single.popped", {31'd0, res_valid}, 32'd0);
      check("single.credit", {31'd0, issue_ready}, 32'd1);

      // Credit exhaustion: tags 0..3 back to back, then a refused 5th issue.
      res_ready = 1'b0; issue_valid = 1'b1;
      for (int t = 0; t < 4; t++) begin
         issue_tag = 4'(t);
         tick();
      end
      check("exhaust.ready_low", {31'd0, issue_ready}, 32'd0);
      issue_tag = 4'hF;
      tick();
      issue_valid = 1'b0; issue_tag = 4'hE;
      check("exhaust.still_low", {31'd0, issue_ready}, 32'd0);
      tick(); tick();
      check_res("exhaust.head0", 4'd0, 10'h002, 10'h007, 2'b00);

      // One pop frees a credit; the issue in that cycle takes it back.
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("fullpop.ready_high", {31'd0, issue_ready}, 32'd1);
      issue_valid = 1'b1; issue_tag = 4'd6;
      tick();
      issue_valid = 1'b0; issue_tag = 4'hD;
      check("fullpop.ready_low", {31'd0, issue_ready}, 32'd0);
      check_res("fullpop.hold1", 4'd1, 10'h003, 10'h006, 2'b00);
      tick(); tick(); tick();
      check_res("fullpop.stable", 4'd1, 10'h003, 10'h006, 2'b00);
      res_ready = 1'b1;
      tick();
      check_res("order.tag2", 4'd2, 10'h004, 10'h005, 2'b00);
      tick();
      check_res("order.tag3", 4'd3, 10'h005, 10'h004, 2'b00);
      tick();
      check_res("order.tag6", 4'd6, 10'h008, 10'h001, 2'b00);
      tick();
      check("order.empty", {31'd0, res_valid}, 32'd0);
      check("order.credits", {31'd0, issue_ready}, 32'd1);

      // Flags: tag 8 -> status 01, tag 9 -> status 11 (pushed while tag 8 pops).
      issue_valid = 1'b1; issue_tag = 4'd8;
      tick();
      issue_tag = 4'd9;
      tick();
      issue_valid = 1'b0; issue_tag = 4'd0;
      tick(); tick();
      check_res("flags.dbz", 4'd8, 10'h00A, 10'h00F, 2'b01);
      tick();
      check_res("flags.both", 4'd9, 10'h00B, 10'h00E, 2'b11);
      tick();
      check("flags.empty", {31'd0, res_valid}, 32'd0);

      // Reset mid-operation: tag 10 buffered, tag 11 in flight.
      res_ready = 1'b0; issue_valid = 1'b1; issue_tag = 4'd10;
      tick();
      issue_valid = 1'b0; issue_tag = 4'd0;
      tick();
      issue_valid = 1'b1; issue_tag = 4'd11;
      tick();
      issue_valid = 1'b0; issue_tag = 4'd0;
      tick();
      check("midrst.buffered", {31'd0, res_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst.res_valid",   {31'd0, res_valid}, 32'd0);
      check("midrst.issue_ready", {31'd0, issue_ready}, 32'd1);
      tick(); tick();
      check("midrst.late_ignored", {31'd0, res_valid}, 32'd0);

      // Exactly four credits after reset; first result out must be tag 12.
      issue_valid = 1'b1;
      for (int t = 12; t < 15; t++) begin
         issue_tag = 4'(t);
         tick();
      end
      check("midrst.credit4", {31'd0, issue_ready}, 32'd1);
      issue_tag = 4'd15;
      tick();
      issue_valid = 1'b0; issue_tag = 4'd0;
      check("midrst.credit0", {31'd0, issue_ready}, 32'd0);
      tick(); tick(); tick();
      res_ready = 1'b1;
      check_res("midrst.tag12", 4'd12, 10'h00E, 10'h00B, 2'b00);
      tick();
      check_res("midrst.tag13", 4'd13, 10'h00F, 10'h00A, 2'b00);
      tick();
      check_res("midrst.tag14", 4'd14, 10'h010, 10'h009, 2'b00);
      tick();
      check_res("midrst.tag15", 4'd15, 10'h011, 10'h008, 2'b00);
      tick();
      check("midrst.drained", {31'd0, res_valid}, 32'd0);

`ifdef DIV_RESULT_COLLECT_DROP_CNT_EN
      // Fill credits, then 300 refused issue cycles saturate the counter.
      res_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("drop.reset", {24'd0, drop_count}, 32'd0);
      issue_valid = 1'b1; issue_tag = 4'd1;
      for (int k = 0; k < 4; k++) tick();
      check("drop.none_yet", {24'd0, drop_count}, 32'd0);
      tick();
      check("drop.one", {24'd0, drop_count}, 32'd1);
      for (int k = 1; k < 300; k++) tick();
      issue_valid = 1'b0;
      check("drop.saturate", {24'd0, drop_count}, 32'd255);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
